// File: rtl/cont_decode_if.sv
// rtl/cont_decode_if.sv - sample bus and decode result signals of cont_decode
interface cont_decode_if #(parameter int WIDTH = 8);
    logic             smp;
    logic [WIDTH-1:0] count_in;
    logic             step_up;
    logic             step_dn;
    logic             wrap;
    logic             err;
    logic             dir_up;
    logic             moving;
    logic             locked;
    logic [7:0]       err_cnt;

    modport master (
        output smp, count_in,
        input  step_up, step_dn, wrap, err, dir_up, moving, locked, err_cnt
    );

    modport slave (
        input  smp, count_in,
        output step_up, step_dn, wrap, err, dir_up, moving, locked, err_cnt
    );
endinterface

// File: rtl/cont_decode.sv
// rtl/cont_decode.sv - up/down counter stream decoder with lock tracking
// Optional macro CONT_DECODE_WRAP_EN: accept all-ones <-> zero steps as legal wraps.
module cont_decode #(
    parameter int WIDTH  = 8,
    parameter int LOCK_N = 4
) (
    input  logic         clk,
    input  logic         reset,
    cont_decode_if.slave bus
);
    typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} state_t;
    typedef enum logic [1:0] {K_HOLD, K_UP, K_DOWN, K_ILLEGAL} kind_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] prev_q, prev_nx;
    logic [3:0]       lock_q, lock_nx, lock_inc;
    logic             up_q, up_nx, dn_q, dn_nx, err_q, err_nx;
    logic             dir_q, dir_nx, mov_q, mov_nx;
    logic [7:0]       ecnt_q, ecnt_nx;
    logic             wrap_nx;

    logic [WIDTH-1:0] delta;
    logic             boundary;
    kind_t            kind;

    assign delta    = bus.count_in - prev_q;
    assign lock_inc = lock_q + 4'd1;
    // A +1 out of all-ones or a -1 out of zero crosses the counter's wrap point.
    assign boundary = ((delta == ONE)  && (prev_q == ALL1)) ||
                      ((delta == ALL1) && (prev_q == ZERO));

    always_comb begin
        kind = K_ILLEGAL;
        if (delta == ZERO)
            kind = K_HOLD;
        else if (delta == ONE)
            kind = K_UP;
        else if (delta == ALL1)
            kind = K_DOWN;
`ifndef CONT_DECODE_WRAP_EN
        if (boundary)
            kind = K_ILLEGAL;
`endif
    end

    always_comb begin
        state_nx = state_q;
        prev_nx  = prev_q;
        lock_nx  = lock_q;
        up_nx    = 1'b0;
        dn_nx    = 1'b0;
        wrap_nx  = 1'b0;
        err_nx   = 1'b0;
        dir_nx   = dir_q;
        mov_nx   = mov_q;
        ecnt_nx  = ecnt_q;
        if (bus.smp) begin
            prev_nx = bus.count_in;
            if (state_q == UNSYNC) begin
                lock_nx  = 4'd0;
                state_nx = ACQUIRE;
            end else if (kind == K_ILLEGAL) begin
                lock_nx = 4'd0;
                mov_nx  = 1'b0;
                if (state_q == LOCKED) begin
                    err_nx   = 1'b1;
                    state_nx = ACQUIRE;
                    if (ecnt_q != 8'hFF)
                        ecnt_nx = ecnt_q + 8'd1;
                end
            end else begin
                up_nx   = (kind == K_UP);
                dn_nx   = (kind == K_DOWN);
                wrap_nx = boundary;
                mov_nx  = (kind != K_HOLD);
                if (kind != K_HOLD)
                    dir_nx = (kind == K_UP);
                if (state_q == ACQUIRE) begin
                    lock_nx = lock_inc;
                    if (lock_inc == 4'(LOCK_N))
                        state_nx = LOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNSYNC;
            prev_q  <= '0;
            lock_q  <= 4'd0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            err_q   <= 1'b0;
            dir_q   <= 1'b0;
            mov_q   <= 1'b0;
            ecnt_q  <= 8'd0;
        end else begin
            state_q <= state_nx;
            prev_q  <= prev_nx;
            lock_q  <= lock_nx;
            up_q    <= up_nx;
            dn_q    <= dn_nx;
            err_q   <= err_nx;
            dir_q   <= dir_nx;
            mov_q   <= mov_nx;
            ecnt_q  <= ecnt_nx;
        end
    end

`ifdef CONT_DECODE_WRAP_EN
    logic wrap_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wrap_q <= 1'b0;
        else
            wrap_q <= wrap_nx;
    end
    assign bus.wrap = wrap_q;
`else
    // Boundary steps are decoded illegal here, so wrap_nx can never rise.
    logic unused_wrap;
    assign unused_wrap = wrap_nx;
    assign bus.wrap    = 1'b0;
`endif

    assign bus.step_up = up_q;
    assign bus.step_dn = dn_q;
    assign bus.err     = err_q;
    assign bus.dir_up  = dir_q;
    assign bus.moving  = mov_q;
    assign bus.locked  = (state_q == LOCKED);
    assign bus.err_cnt = ecnt_q;
endmodule

// File: tb/tb_cont_decode.sv
// tb/tb_cont_decode.sv - scoreboard bench for cont_decode against a behavioural model
module tb_cont_decode;
    localparam int LOCK_N = 4;
`ifdef CONT_DECODE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cont_decode_if #(.WIDTH(8)) bus ();
    cont_decode #(.WIDTH(8), .LOCK_N(LOCK_N)) dut (.clk(clk), .reset(reset), .bus(bus));

    // layout: step_up step_dn wrap err dir_up moving locked err_cnt[7:0]
    typedef logic [14:0] vec_t;
    vec_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    // reference state, in terms of the observed stream
    bit have_prev;
    int prev_v, run, err_total;
    bit m_locked, m_dir, m_moving;

    function automatic vec_t actual();
        return {bus.step_up, bus.step_dn, bus.wrap, bus.err, bus.dir_up,
                bus.moving, bus.locked, bus.err_cnt};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s cycle %0d: got up=%b dn=%b wrap=%b err=%b dir=%b mov=%b lock=%b ecnt=%0d, want up=%b dn=%b wrap=%b err=%b dir=%b mov=%b lock=%b ecnt=%0d",
                     name, cycle, act[14], act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    endtask

    function automatic void model_reset();
        have_prev = 0; prev_v = 0; run = 0; err_total = 0;
        m_locked = 0; m_dir = 0; m_moving = 0;
    endfunction

    function automatic vec_t model_step(input bit s, input int v);
        bit up = 0, dn = 0, wr = 0, er = 0;
        if (s) begin
            if (!have_prev) begin
                have_prev = 1;
                run = 0;
            end else begin
                int  d   = (v - prev_v + 256) % 256;
                bit  bnd = (prev_v == 255 && v == 0) || (prev_v == 0 && v == 255);
                bit  ok  = (d == 0 || d == 1 || d == 255) && (WRAP_EN || !bnd);
                if (ok) begin
                    up = (d == 1);
                    dn = (d == 255);
                    wr = bnd;
                    m_moving = (d != 0);
                    if (d != 0) m_dir = (d == 1);
                    if (!m_locked) begin
                        run++;
                        if (run == LOCK_N) m_locked = 1;
                    end
                end else begin
                    m_moving = 0;
                    run = 0;
                    if (m_locked) begin
                        er = 1;
                        err_total++;
                        m_locked = 0;
                    end
                end
            end
            prev_v = v;
        end
        return {up, dn, wr, er, m_dir, m_moving, m_locked,
                8'((err_total > 255) ? 255 : err_total)};
    endfunction

    task automatic cyc(input bit s, input int v);
        bus.smp      = s;
        bus.count_in = 8'(v);
        @(posedge clk);
        sb.push_back(model_step(s, v));
        #1;
    endtask

    task automatic relock(input int v);
        repeat (LOCK_N + 1) cyc(1, v);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", actual(), model_step(0, 0));
        sb.push_back(model_step(0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        cycle++;
        if (sb.size() > 0)
            check("scoreboard", actual(), sb.pop_front());
    end

    initial begin
        int v;
        reset        = 1'b0;
        bus.smp      = 1'b0;
        bus.count_in = '0;
        model_reset();
        sb.push_back(model_step(0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 10; i <= 14; i++) cyc(1, i);
        relock(51);
        cyc(1, 50); cyc(1, 49); cyc(1, 49); cyc(1, 48);
        relock(20);
        cyc(1, 25);
        for (int i = 26; i <= 29; i++) cyc(1, i);
        relock(254);
        cyc(1, 255); cyc(1, 0); cyc(1, 1);
        relock(1);
        cyc(1, 0); cyc(1, 255); cyc(0, 3); cyc(1, 254);

        v = 128;
        for (int i = 0; i < 2000; i++) begin
            int r = $urandom_range(99);
            if (r < 40)       v = (v + 1) % 256;
            else if (r < 70)  v = (v + 255) % 256;
            else if (r < 80)  v = v;
            else if (r < 90)  v = $urandom_range(255);
            else              v = ($urandom_range(1) != 0) ? 254 : 1;
            cyc(($urandom_range(3) != 0), v);
        end

        v = 0;
        relock(v);
        for (int i = 0; i < 300; i++) begin
            v = (v + 10) % 256;
            cyc(1, v);
            repeat (LOCK_N) begin
                v = (v + 1) % 256;
                cyc(1, v);
            end
        end
        check("err_cnt_saturated", {7'b0, bus.err_cnt}, 15'd255);

        relock(100);
        cyc(1, 101); cyc(1, 102);
        mid_reset();
        cyc(1, 103); cyc(1, 104); cyc(1, 105);
        cyc(0, 0); cyc(0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 15'(sb.size()), 15'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
